// File: rtl/condicionador_sensores.sv
// condicionador_sensores: synchronizes, debounces and validates five tank level
// probes (0 = wet, 1 = dry), then publishes a conditioned vector, a level code,
// a fault flag and a one-cycle level-change pulse.
// Optional build macro: HOLD_ON_FAULT_EN freezes sensores_out/nivel at their
// last OK values while the fault FSM is in FALHA or SAIDA.
module condicionador_sensores #(
    parameter int unsigned DEB_CNT   = 1000,
    parameter int unsigned FAULT_CNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sensores_raw,
    output logic [4:0] sensores_out,
    output logic [2:0] nivel,
    output logic       fault,
    output logic       changed
);

    localparam int unsigned N_SENS = 5;
    localparam int unsigned NIV_W  = 3;
    localparam int unsigned DEB_W  = 16;
    localparam int unsigned FLT_W  = 8;

    // Last count value before a change is accepted (reaching DEB_CNT / FAULT_CNT).
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FAULT_CNT - 1);

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_SUSPEITO = 2'd1,
        ST_FALHA    = 2'd2,
        ST_SAIDA    = 2'd3
    } state_t;

    logic [N_SENS-1:0] sync_q1;
    logic [N_SENS-1:0] sync_q2;
    logic [N_SENS-1:0] deb;
    logic [N_SENS-1:0] wet;
    logic              deb_consistent;

    state_t            state_q;
    state_t            state_d;
    logic [FLT_W-1:0]  flt_cnt_q;
    logic [FLT_W-1:0]  flt_cnt_d;

    logic              update_en;
    logic [N_SENS-1:0] out_d;
    logic [NIV_W-1:0]  nivel_d;
    logic              fault_d;

    // Level code: index of the highest wet probe plus one, 0 when all dry.
    function automatic logic [NIV_W-1:0] level_of(input logic [N_SENS-1:0] v);
        logic [NIV_W-1:0] lvl;
        lvl = '0;
        for (int i = 0; i < N_SENS; i++) begin
            if (!v[i]) begin
                lvl = NIV_W'(i + 1);
            end
        end
        return lvl;
    endfunction

    // Two-flop synchronizer for the asynchronous probe inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= sensores_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Independent per-bit debouncers; counter clears on agreement, accepts at DEB_CNT.
    for (genvar g = 0; g < N_SENS; g++) begin : g_deb
        logic [DEB_W-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                deb[g] <= 1'b1;
            end else if (sync_q2[g] == deb[g]) begin
                cnt <= '0;
            end else if (cnt >= DEB_LAST) begin
                cnt    <= '0;
                deb[g] <= sync_q2[g];
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

    // Wet probes must form a contiguous run from bit0: wet mask is 2^k - 1.
    assign wet            = ~deb;
    assign deb_consistent = ((wet & (wet + N_SENS'(1))) == '0);

    // FSM state and fault-persistence counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OK;
            flt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    // Next-state logic; counter includes the cycle that entered SUSPEITO/SAIDA.
    always_comb begin
        state_d   = state_q;
        flt_cnt_d = flt_cnt_q;
        case (state_q)
            ST_OK: begin
                if (!deb_consistent) begin
                    state_d   = ST_SUSPEITO;
                    flt_cnt_d = FLT_W'(1);
                end
            end
            ST_SUSPEITO: begin
                if (deb_consistent) begin
                    state_d   = ST_OK;
                    flt_cnt_d = '0;
                end else if (flt_cnt_q >= FLT_LAST) begin
                    state_d   = ST_FALHA;
                    flt_cnt_d = '0;
                end else begin
                    flt_cnt_d = flt_cnt_q + FLT_W'(1);
                end
            end
            ST_FALHA: begin
                if (deb_consistent) begin
                    state_d   = ST_SAIDA;
                    flt_cnt_d = FLT_W'(1);
                end
            end
            ST_SAIDA: begin
                if (!deb_consistent) begin
                    state_d   = ST_FALHA;
                    flt_cnt_d = '0;
                end else if (flt_cnt_q >= FLT_LAST) begin
                    state_d   = ST_OK;
                    flt_cnt_d = '0;
                end else begin
                    flt_cnt_d = flt_cnt_q + FLT_W'(1);
                end
            end
            default: begin
                state_d   = ST_OK;
                flt_cnt_d = '0;
            end
        endcase
    end

    // Output decode: OK tracks deb (only ever consistent there), SUSPEITO holds.
    always_comb begin
        update_en = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            ST_OK: begin
                update_en = 1'b1;
            end
            ST_FALHA, ST_SAIDA: begin
                fault_d = 1'b1;
`ifdef HOLD_ON_FAULT_EN
                update_en = 1'b0;
`else
                update_en = 1'b1;
`endif
            end
            default: begin
                update_en = 1'b0;
            end
        endcase
        out_d   = update_en ? deb : sensores_out;
        nivel_d = level_of(out_d);
    end

    // Registered outputs; changed flags the edge where nivel takes a new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sensores_out <= '1;
            nivel        <= '0;
            fault        <= 1'b0;
            changed      <= 1'b0;
        end else begin
            sensores_out <= out_d;
            nivel        <= nivel_d;
            fault        <= fault_d;
            changed      <= (nivel_d != nivel);
        end
    end

endmodule

// File: tb/tb_condicionador_sensores.sv
// Directed self-checking bench for condicionador_sensores (DEB_CNT=4, FAULT_CNT=3).
// Works with or without HOLD_ON_FAULT_EN defined.
module tb_condicionador_sensores;

    localparam int unsigned DEB_CNT   = 4;
    localparam int unsigned FAULT_CNT = 3;
`ifdef HOLD_ON_FAULT_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] sensores_raw = 5'b11111;
    logic [4:0] sensores_out;
    logic [2:0] nivel;
    logic       fault;
    logic       changed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] out;
        logic [2:0] niv;
        int         pulses;
    } vec_t;

    vec_t tbl [7];

    condicionador_sensores #(
        .DEB_CNT   (DEB_CNT),
        .FAULT_CNT (FAULT_CNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensores_raw (sensores_raw),
        .sensores_out (sensores_out),
        .nivel        (nivel),
        .fault        (fault),
        .changed      (changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [4:0] e_out,
                           input logic [2:0] e_niv, input logic e_f, input logic e_ch);
        chk({name, ".out"},     int'(sensores_out), int'(e_out));
        chk({name, ".nivel"},   int'(nivel),        int'(e_niv));
        chk({name, ".fault"},   int'(fault),        int'(e_f));
        chk({name, ".changed"}, int'(changed),      int'(e_ch));
    endtask

    initial begin
        int pulses;

        tbl[0] = '{5'b11111, 5'b11111, 3'd0, 1};
        tbl[1] = '{5'b11110, 5'b11110, 3'd1, 1};
        tbl[2] = '{5'b11000, 5'b11000, 3'd3, 1};
        tbl[3] = '{5'b10000, 5'b10000, 3'd4, 1};
        tbl[4] = '{5'b00000, 5'b00000, 3'd5, 1};
        tbl[5] = '{5'b11100, 5'b11100, 3'd2, 1};
        tbl[6] = '{5'b11100, 5'b11100, 3'd2, 0};

        // Reset held with random probes, then released with all dry.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sensores_raw = 5'($urandom);
            tick();
            chk_all("reset", 5'b11111, 3'd0, 1'b0, 1'b0);
        end
        sensores_raw = 5'b11111;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_exit.changed", int'(changed), 0);
        end

        // Glitch: bit0 wet for 3 cycles only.
        sensores_raw = 5'b11110;
        repeat (3) tick();
        sensores_raw = 5'b11111;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("glitch.out", int'(sensores_out), 5'b11111);
            chk("glitch.changed", int'(changed), 0);
        end

        // Clean step to 11100: visible on the 7th edge after the change.
        sensores_raw = 5'b11100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("step_wait.out", int'(sensores_out), 5'b11111);
            chk("step_wait.changed", int'(changed), 0);
        end
        tick();
        chk_all("step", 5'b11100, 3'd2, 1'b0, 1'b1);
        tick();
        chk("step_after.changed", int'(changed), 0);

        // Fault: impossible pattern 01111 held.
        sensores_raw = 5'b01111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("fault_wait.fault", int'(fault), 0);
            chk("fault_wait.out", int'(sensores_out), 5'b11100);
            chk("fault_wait.nivel", int'(nivel), 2);
        end
        tick();
        chk_all("fault_entry", HOLD ? 5'b11100 : 5'b01111, HOLD ? 3'd2 : 3'd5,
                1'b1, HOLD ? 1'b0 : 1'b1);
        tick();
        chk("fault_after.changed", int'(changed), 0);
        chk("fault_after.fault", int'(fault), 1);

        // Recovery to 00000 through SAIDA.
        sensores_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("recov_wait.fault", int'(fault), 1);
            if (k == 7) begin
                chk("recov_saida.out", int'(sensores_out), HOLD ? 5'b11100 : 5'b00000);
                chk("recov_saida.nivel", int'(nivel), HOLD ? 2 : 5);
                chk("recov_saida.changed", int'(changed), 0);
            end
        end
        tick();
        chk_all("recov_ok", 5'b00000, 3'd5, 1'b0, HOLD ? 1'b1 : 1'b0);
        tick();
        chk("recov_after.changed", int'(changed), 0);

        // Re-enter FALHA, then a one-cycle inconsistency inside SAIDA.
        sensores_raw = 5'b01111;
        repeat (10) tick();
        chk("refault.fault", int'(fault), 1);
        sensores_raw = 5'b11111;
        tick();
        sensores_raw = 5'b11101;
        tick();
        sensores_raw = 5'b11100;
        for (int k = 3; k <= 10; k++) begin
            tick();
            chk("saida_glitch.fault", int'(fault), 1);
            if (k == 7) begin
                chk_all("saida_glitch7", HOLD ? 5'b00000 : 5'b11111, HOLD ? 3'd5 : 3'd0,
                        1'b1, HOLD ? 1'b0 : 1'b1);
            end
            if (k == 8) begin
                chk_all("saida_glitch8", HOLD ? 5'b00000 : 5'b11101, HOLD ? 3'd5 : 3'd2,
                        1'b1, HOLD ? 1'b0 : 1'b1);
            end
        end
        tick();
        chk_all("saida_exit", 5'b11100, 3'd2, 1'b0, HOLD ? 1'b1 : 1'b0);

        // Table of consistent steady-state levels with changed-pulse counts.
        for (int i = 0; i < 7; i++) begin
            sensores_raw = tbl[i].raw;
            pulses = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (changed) pulses++;
            end
            chk($sformatf("tbl%0d.out", i), int'(sensores_out), int'(tbl[i].out));
            chk($sformatf("tbl%0d.nivel", i), int'(nivel), int'(tbl[i].niv));
            chk($sformatf("tbl%0d.fault", i), int'(fault), 0);
            chk($sformatf("tbl%0d.pulses", i), pulses, tbl[i].pulses);
        end

        // Reset 2 cycles into a debounce: pending change restarts from scratch.
        sensores_raw = 5'b11000;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 5'b11111, 3'd0, 1'b0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rst_mid_wait.out", int'(sensores_out), 5'b11111);
            chk("rst_mid_wait.changed", int'(changed), 0);
        end
        tick();
        chk_all("rst_mid_done", 5'b11000, 3'd3, 1'b0, 1'b1);

        // Reset while in FALHA: immediate clear, quiet exit.
        sensores_raw = 5'b01111;
        repeat (12) tick();
        chk("falha_pre.fault", int'(fault), 1);
        rst_n = 1'b0;
        #1;
        chk_all("rst_falha", 5'b11111, 3'd0, 1'b0, 1'b0);
        sensores_raw = 5'b11111;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_falha_exit.changed", int'(changed), 0);
            chk("rst_falha_exit.fault", int'(fault), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
